// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding, count-width helper and default width for piso_tx_reg
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Wide enough to hold WIDTH itself, which the parity beat index reaches.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// rtl/piso_bit_cnt.sv - beat counter with clear/increment, last-data-bit and terminal flags
module piso_bit_cnt #(
  parameter int CW       = 4,
  parameter int DATA_END = 7,
  parameter int TERM     = 7
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic inc,
  output logic data_end,
  output logic terminal
);

  logic [CW-1:0] count;

  // Saturates at TERM so the index never wraps past the final beat.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !terminal) begin
      count <= count + 1'b1;
    end
  end

  assign data_end = (count == CW'(DATA_END));
  assign terminal = (count == CW'(TERM));

endmodule

// File: rtl/piso_tx_reg.sv
// rtl/piso_tx_reg.sv - parallel-in/serial-out transmit register; PIPO_PARITY_EN adds an even-parity beat
module piso_tx_reg
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_date,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
`ifdef PIPO_PARITY_EN
  localparam int TERM = WIDTH;
`else
  localparam int TERM = WIDTH - 1;
`endif

  piso_state_e      state, state_next;
  logic [WIDTH-1:0] shifter;
  logic             data_end, terminal, beat, accept;

  piso_bit_cnt #(
    .CW       (CW),
    .DATA_END (WIDTH - 1),
    .TERM     (TERM)
  ) u_cnt (
    .clk      (clk),
    .clr      (clr),
    .clear    (accept),
    .inc      (beat & ~accept),
    .data_end (data_end),
    .terminal (terminal)
  );

`ifdef PIPO_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clk) begin
    if (clr) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= ^in_date;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      shifter <= '0;
    end else if (accept) begin
      shifter <= in_date;
    end else if (beat && state == SHIFT) begin
      shifter <= MSB_FIRST ? {shifter[WIDTH-2:0], 1'b0} : {1'b0, shifter[WIDTH-1:1]};
    end
  end

  // A new word may be taken in the same cycle the final bit leaves, giving zero-gap streaming.
  always_comb begin
    state_next = state;
    ser_valid  = (state != IDLE);
    busy       = (state != IDLE);
    ser_last   = terminal & (state != IDLE);
    ser_out    = 1'b0;
    beat       = ser_valid & ser_ready;
    in_ready   = ~clr & ((state == IDLE) | (ser_last & beat));
    accept     = in_valid & in_ready;
    case (state)
      IDLE: begin
        if (accept) state_next = SHIFT;
      end
      SHIFT: begin
        ser_out = MSB_FIRST ? shifter[WIDTH-1] : shifter[0];
        if (beat && data_end) begin
`ifdef PIPO_PARITY_EN
          state_next = PARITY;
`else
          state_next = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PIPO_PARITY_EN
      PARITY: begin
        ser_out = parity_bit;
        if (beat) state_next = accept ? SHIFT : IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

endmodule
